// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: frame-level control for the pipelined radix-2 FFT datapath.
// Loads N = 2^NUMSTAGES samples, runs NUMSTAGES butterfly passes of 2^CNT_W
// cycles each, then unloads the result and pulses done.
// Optional build macro: FFT_SEQ_BITREV_EN -- UNLOAD addr presents bit-reversed index.
module fft_stage_sequencer #(
  parameter int unsigned NUMSTAGES = 5,
  parameter int unsigned CNT_W     = NUMSTAGES - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUMSTAGES-1:0] addr,
  output logic                 ld_data,
  output logic [CNT_W-1:0]     counter,
  output logic [2:0]           stage_num,
  output logic                 busy,
  output logic                 done
);

  localparam logic [NUMSTAGES-1:0] IDX_MAX    = '1;
  localparam logic [CNT_W-1:0]     CNT_MAX    = '1;
  localparam logic [2:0]           STAGE_LAST = 3'(NUMSTAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_UNLOAD
  } state_t;

  state_t                 state_q, state_d;
  logic [NUMSTAGES-1:0]   idx_q, idx_d;
  logic [NUMSTAGES-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]       counter_q, counter_d;
  logic [2:0]             stage_q, stage_d;
  logic                   ld_data_q, ld_data_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

`ifdef FFT_SEQ_BITREV_EN
  // Mirror the index across NUMSTAGES bits for bit-reversed unload order.
  function automatic logic [NUMSTAGES-1:0] bitrev(input logic [NUMSTAGES-1:0] v);
    logic [NUMSTAGES-1:0] r;
    for (int b = 0; b < int'(NUMSTAGES); b++) begin
      r[b] = v[int'(NUMSTAGES) - 1 - b];
    end
    return r;
  endfunction
`endif

  // Next-state, beat counting and next values of every registered output.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    counter_d = counter_q;
    stage_d   = stage_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d     = '0;
        counter_d = '0;
        stage_d   = '0;
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          if (idx_q == IDX_MAX) begin
            idx_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            idx_d = idx_q + NUMSTAGES'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (counter_q == CNT_MAX) begin
          counter_d = '0;
          // >= keeps stage_num bounded even from an unexpected value
          if (stage_q >= STAGE_LAST) begin
            stage_d = '0;
            state_d = S_UNLOAD;
          end else begin
            stage_d = stage_q + 3'(1);
          end
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      S_UNLOAD: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == IDX_MAX) begin
            idx_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + NUMSTAGES'(1);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        idx_d     = '0;
        counter_d = '0;
        stage_d   = '0;
      end
    endcase

    ld_data_d   = (state_d == S_IDLE) || (state_d == S_LOAD);
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_UNLOAD);
    busy_d      = (state_d != S_IDLE);
`ifdef FFT_SEQ_BITREV_EN
    addr_d      = (state_d == S_UNLOAD) ? bitrev(idx_d) : idx_d;
`else
    addr_d      = idx_d;
`endif
  end

  // State and output registers; reset forces IDLE values with done low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      counter_q   <= '0;
      stage_q     <= '0;
      ld_data_q   <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      counter_q   <= counter_d;
      stage_q     <= stage_d;
      ld_data_q   <= ld_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign addr      = addr_q;
  assign ld_data   = ld_data_q;
  assign counter   = counter_q;
  assign stage_num = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
